// File: rtl/npu_result_reader.sv
// npu_result_reader
// Sweeps NUM_CH NPU result channels one after another once save_finish is
// seen. Pairs of 16-bit results are packed into 32-bit words and buffered in
// a first-word-fall-through FIFO. The FIFO drives a framed output stream
// (out_sop on the first word of the sweep, out_eop on the last word).
//
// Optional feature: define RD_TIMEOUT_EN to add a per-channel read timeout.
// On expiry the partial word is dropped, a zero eop word closes the frame,
// and the sticky err output is set.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   save_finish          starts one sweep when idle
//   rd_sop[NUM_CH]       one-cycle read start pulse for the selected channel
//   rd_vld/rd_eop        per-channel result valid / last result
//   rd_data              16 bits per channel, channel i at [16i+15:16i]
//   out_*                output stream; a word transfers on out_vld && out_rdy
//   busy, done           sweep in progress / one-cycle end-of-frame pulse
//   err                  sticky timeout flag (RD_TIMEOUT_EN only)
module npu_result_reader #(
    parameter int NUM_CH       = 8,
    parameter int BEATS_PER_CH = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   save_finish,
    output logic [NUM_CH-1:0]      rd_sop,
    input  logic [NUM_CH-1:0]      rd_vld,
    input  logic [NUM_CH-1:0]      rd_eop,
    input  logic [16*NUM_CH-1:0]   rd_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_vld,
    output logic [31:0]            out_data,
    input  logic                   out_rdy,
    output logic                   busy,
    output logic                   done
`ifdef RD_TIMEOUT_EN
    ,
    output logic                   err
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BT_W = $clog2(BEATS_PER_CH) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [BT_W-1:0] BEATS     = BT_W'(BEATS_PER_CH);
    localparam logic [BT_W-1:0] BEAT_LAST = BT_W'(BEATS_PER_CH - 1);
    localparam logic [CW-1:0]   HALF      = CW'(BEATS_PER_CH / 2);
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        COLLECT = 3'd2,
        NEXT    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BT_W-1:0]     beat_q, beat_d;
    logic [31:0]         pack_q, pack_d;
    logic                pend_q, pend_d;   // full word held back awaiting eop
    logic                first_q, first_d; // next pushed word opens the frame
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CH-1:0]   rd_sop_q, rd_sop_d;

    // FIFO entry: {sop, eop, data}
    logic [33:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q;
    logic                push_s, pop_s, eop_xfer_s;
    logic [33:0]         push_word_s, head_s;
    logic [CW-1:0]       free_s;

    logic                sel_vld_s, sel_eop_s, last_ch_s;
    logic [15:0]         sel_data_s;

`ifdef RD_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                err_q, err_d;
    assign err = err_q;
`endif

    // Only the currently selected channel is visible to the collector.
    assign sel_vld_s  = rd_vld[ch_q];
    assign sel_eop_s  = rd_eop[ch_q];
    assign sel_data_s = rd_data[{ch_q, 4'h0} +: 16];
    assign last_ch_s  = (ch_q == LAST_CH);

    assign head_s     = mem_q[rd_ptr_q];
    assign out_vld    = (cnt_q != {CW{1'b0}});
    assign out_data   = out_vld ? head_s[31:0] : 32'h0000_0000;
    assign out_eop    = out_vld & head_s[32];
    assign out_sop    = out_vld & head_s[33];
    assign pop_s      = out_vld & out_rdy;
    assign eop_xfer_s = pop_s & head_s[32];
    assign free_s     = DEPTH_C - cnt_q;

    assign rd_sop = rd_sop_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // Sweep sequencing, beat packing and FIFO push generation.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        beat_d      = beat_q;
        pack_d      = pack_q;
        pend_d      = pend_q;
        first_d     = first_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_sop_d    = {NUM_CH{1'b0}};
        push_s      = 1'b0;
        push_word_s = 34'h0_0000_0000;
`ifdef RD_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (save_finish) begin
                    ch_d    = {CH_W{1'b0}};
                    busy_d  = 1'b1;
                    first_d = 1'b1;
`ifdef RD_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // Room for a full channel guarantees the FIFO never overflows.
                if (free_s >= HALF) begin
                    rd_sop_d = NUM_CH'(1) << ch_q;
                    beat_d   = {BT_W{1'b0}};
                    pack_d   = 32'h0000_0000;
                    pend_d   = 1'b0;
`ifdef RD_TIMEOUT_EN
                    tmo_d    = {TW{1'b0}};
`endif
                    state_d  = COLLECT;
                end else begin
                    state_d  = ISSUE;
                end
            end
            COLLECT: begin
                if (sel_vld_s) begin
`ifdef RD_TIMEOUT_EN
                    tmo_d = {TW{1'b0}};
`endif
                    if (beat_q < BEATS) begin
                        beat_d = beat_q + BT_W'(1);
                        if (!beat_q[0]) begin
                            pack_d = {16'h0000, sel_data_s};
                            push_s = sel_eop_s;
                            push_word_s = {first_q, last_ch_s, 16'h0000, sel_data_s};
                        end else if (sel_eop_s || (beat_q != BEAT_LAST)) begin
                            push_s = 1'b1;
                            push_word_s = {first_q, sel_eop_s & last_ch_s, sel_data_s, pack_q[15:0]};
                        end else begin
                            // Last kept beat without eop: hold the word so the
                            // eop tag can still be attached when eop arrives.
                            pack_d = {sel_data_s, pack_q[15:0]};
                            pend_d = 1'b1;
                        end
                    end else begin
                        // Surplus beat: dropped, but its eop flushes a held word.
                        push_s = sel_eop_s & pend_q;
                        push_word_s = {first_q, last_ch_s, pack_q};
                    end
                    if (sel_eop_s) begin
                        pend_d  = 1'b0;
                        state_d = NEXT;
                    end else begin
                        state_d = COLLECT;
                    end
`ifdef RD_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    err_d       = 1'b1;
                    pack_d      = 32'h0000_0000;
                    pend_d      = 1'b0;
                    push_s      = 1'b1;
                    push_word_s = {first_q, 1'b1, 32'h0000_0000};
                    state_d     = DRAIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`else
                end else begin
                    state_d = COLLECT;
`endif
                end
                if (push_s) begin
                    first_d = 1'b0;
                end else begin
                    first_d = first_q;
                end
            end
            NEXT: begin
                if (!last_ch_s) begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = ISSUE;
                end else if (eop_xfer_s) begin
                    // The eop word can leave the FIFO before DRAIN is reached.
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (eop_xfer_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= {CH_W{1'b0}};
            beat_q   <= {BT_W{1'b0}};
            pack_q   <= 32'h0000_0000;
            pend_q   <= 1'b0;
            first_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_sop_q <= {NUM_CH{1'b0}};
`ifdef RD_TIMEOUT_EN
            tmo_q    <= {TW{1'b0}};
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            beat_q   <= beat_d;
            pack_q   <= pack_d;
            pend_q   <= pend_d;
            first_q  <= first_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_sop_q <= rd_sop_d;
`ifdef RD_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            cnt_q    <= cnt_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // FIFO storage; contents are masked at the output while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_word_s;
        end
    end

endmodule

// File: tb/tb_npu_result_reader.sv
module tb_npu_result_reader;
    localparam int NUM_CH = 8;
    localparam int BEATS  = 16;
    localparam int NROWS  = 6;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 save_finish;
    logic [NUM_CH-1:0]    rd_sop;
    logic [NUM_CH-1:0]    rd_vld;
    logic [NUM_CH-1:0]    rd_eop;
    logic [16*NUM_CH-1:0] rd_data;
    logic                 out_sop, out_eop, out_vld;
    logic [31:0]          out_data;
    logic                 out_rdy;
    logic                 busy, done;
`ifdef RD_TIMEOUT_EN
    logic                 err;
`endif

    always #5 clk = ~clk;

    npu_result_reader dut (
        .clk(clk), .rst_n(rst_n), .save_finish(save_finish),
        .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_eop(rd_eop), .rd_data(rd_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_vld(out_vld),
        .out_data(out_data), .out_rdy(out_rdy), .busy(busy), .done(done)
`ifdef RD_TIMEOUT_EN
        , .err(err)
`endif
    );

    typedef struct packed {
        logic [NUM_CH-1:0][7:0] len;       // beats returned per channel
        logic                   aval;      // channel 3 returns 00A1, 00A2, ...
        logic [7:0]             rdy_hold;  // cycles of out_rdy=0 at sweep start
        logic                   interfere; // noise on channel 5 during channel 1
        logic                   sf_mid;    // save_finish pulse during channel 3
        logic [7:0]             exp_words;
    } row_t;

    row_t        rows [NROWS];
    logic [33:0] exp_q [$];
    int          compared = 0, mismatched = 0;
    int          words, done_cnt, sop_cnt, sop2_words;
    logic [NUM_CH-1:0] sop_seen;
    logic [31:0] first_word, last_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] beat_val(row_t r, int ch, int k);
        if (r.aval && ch == 3) return 16'h00A1 + 16'(k);
        else return {4'h0, 4'(ch), 4'h0, 4'(k)};
    endfunction

    // Output monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_sop[2] && sop2_words < 0) sop2_words = words;
            if (rd_sop != '0) begin
                sop_cnt += $countones(rd_sop);
                sop_seen |= rd_sop;
            end
            if (done) done_cnt++;
            if (out_vld && out_rdy) begin
                words++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got %h, expected no word", out_data);
                end else begin
                    check("stream_word", {30'h0, out_sop, out_eop, out_data}, {30'h0, exp_q.pop_front()});
                    if (words == 1) first_word = out_data;
                    last_word = out_data;
                end
            end
        end
    end

    task automatic wait_sop(input int ch, output bit got);
        got = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (rd_sop[ch]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL rd_sop_wait ch%0d: got no pulse, expected one", ch);
        end
    endtask

    task automatic drive_channel(input row_t r, input int ch);
        int n, len;
        bit got;
        len = int'(r.len[ch]);
        wait_sop(ch, got);
        if (!got) return;
        n = (len < BEATS) ? len : BEATS;
        for (int j = 0; j < n; j += 2)
            exp_q.push_back({(ch == 0 && j == 0), (ch == NUM_CH-1 && j + 2 >= n),
                             ((j + 1 < n) ? beat_val(r, ch, j + 1) : 16'h0000),
                             beat_val(r, ch, j)});
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            rd_vld[ch] = 1'b1;
            rd_eop[ch] = (k == len - 1);
            rd_data[ch*16 +: 16] = beat_val(r, ch, k);
            if (r.interfere && ch == 1) begin
                rd_vld[5] = 1'b1;
                rd_eop[5] = 1'b1;
                rd_data[80 +: 16] = 16'hDEAD;
            end
            save_finish = (r.sf_mid && ch == 3 && k == 0);
        end
        @(posedge clk); #1;
        rd_vld = '0;
        rd_eop = '0;
        save_finish = 1'b0;
    endtask

    task automatic start_sweep();
        words = 0; done_cnt = 0; sop_cnt = 0; sop2_words = -1; sop_seen = '0;
        @(posedge clk); #1 save_finish = 1'b1;
        @(posedge clk); #1 save_finish = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got busy=1, expected busy=0", name);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic run_row(input int i);
        row_t r;
        r = rows[i];
        out_rdy = (r.rdy_hold == 8'd0);
        start_sweep();
        fork
            begin
                if (r.rdy_hold != 8'd0) begin
                    repeat (int'(r.rdy_hold)) @(posedge clk);
                    #1;
                    check("sop2_withheld", sop_seen[2], 1'b0);
                    check("busy_in_sweep", busy, 1'b1);
                    out_rdy = 1'b1;
                end
            end
            begin
                for (int c = 0; c < NUM_CH; c++) drive_channel(r, c);
            end
        join
        wait_idle("sweep");
        check("word_count", words, r.exp_words);
        check("done_pulses", done_cnt, 1);
        check("rd_sop_pulses", sop_cnt, NUM_CH);
        check("queue_empty", exp_q.size(), 0);
        check("busy_after", busy, 1'b0);
        if (r.rdy_hold != 8'd0) check("sop2_after_8_free", (sop2_words >= 8), 1'b1);
        if (i == 0) begin
            check("first_word", first_word, 32'h0001_0000);
            check("last_word", last_word, 32'h070F_070E);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int i = 0; i < NROWS; i++) begin
            rows[i].len       = {NUM_CH{8'd16}};
            rows[i].aval      = 1'b0;
            rows[i].rdy_hold  = 8'd0;
            rows[i].interfere = 1'b0;
            rows[i].sf_mid    = 1'b0;
            rows[i].exp_words = 8'd64;
        end
        rows[1].len[3] = 8'd3;  rows[1].aval = 1'b1;   rows[1].exp_words = 8'd58;
        rows[2].rdy_hold = 8'd60;
        rows[3].interfere = 1'b1; rows[3].sf_mid = 1'b1;
        rows[4].len[0] = 8'd1;  rows[4].len[4] = 8'd2; rows[4].len[7] = 8'd20;
        rows[4].exp_words = 8'd50;
        rows[5].len = {NUM_CH{8'd15}};

        rst_n = 1'b0; save_finish = 1'b0; rd_vld = '0; rd_eop = '0; rd_data = '0; out_rdy = 1'b1;
        #12;
        check("rst_out_vld", out_vld, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_sop_eop", {out_sop, out_eop}, 2'b00);
        check("rst_rd_sop", rd_sop, '0);
        check("rst_busy_done", {busy, done}, 2'b00);
`ifdef RD_TIMEOUT_EN
        check("rst_err", err, 1'b0);
`endif
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < NROWS; i++) run_row(i);

        // Reset in the middle of channel 2 discards everything.
        out_rdy = 1'b1;
        start_sweep();
        drive_channel(rows[0], 0);
        drive_channel(rows[0], 1);
        wait_sop(2, got);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            rd_vld[2] = 1'b1;
            rd_data[32 +: 16] = beat_val(rows[0], 2, k);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_vld", out_vld, 1'b0);
        check("midrst_out_data", out_data, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rd_sop", rd_sop, '0);
        rd_vld = '0;
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        run_row(0);

`ifdef RD_TIMEOUT_EN
        // Channel 6 stalls without eop: frame closes with a zero eop word.
        out_rdy = 1'b1;
        start_sweep();
        for (int c = 0; c < 6; c++) drive_channel(rows[0], c);
        wait_sop(6, got);
        exp_q.push_back({2'b00, beat_val(rows[0], 6, 1), beat_val(rows[0], 6, 0)});
        exp_q.push_back({2'b00, beat_val(rows[0], 6, 3), beat_val(rows[0], 6, 2)});
        exp_q.push_back({2'b01, 32'h0});
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            rd_vld[6] = 1'b1;
            rd_data[96 +: 16] = beat_val(rows[0], 6, k);
        end
        @(posedge clk); #1 rd_vld = '0;
        wait_idle("timeout");
        check("tmo_err", err, 1'b1);
        check("tmo_done", done_cnt, 1);
        check("tmo_words", words, 6 * 8 + 3);
        check("tmo_queue_empty", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
